// File: rtl/lu_band_sequencer.sv
// Sequences one LU band-matrix pass: serial element load, skew feed (count 0..LAST_COUNT), array drain, done pulse.
// Optional build macro LU_SEQ_STALL_EN adds a stall input that freezes FEED/DRAIN progress.
module lu_band_sequencer #(
   parameter int DATA_W       = 8,
   parameter int N_ELEM       = 44,
   parameter int LAST_COUNT   = 21,
   parameter int DRAIN_CYCLES = 8,
   parameter int IDLE_COUNT   = 31
) (
   input  logic                       clk,
   input  logic                       rst_n,
`ifdef LU_SEQ_STALL_EN
   input  logic                       stall,
`endif
   input  logic                       start,
   input  logic                       in_valid,
   input  logic [DATA_W-1:0]          in_data,
   output logic                       in_ready,
   output logic [N_ELEM*DATA_W-1:0]   band_flat,
   output logic [4:0]                 count,
   output logic                       array_en,
   output logic                       busy,
   output logic                       done
);

   localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [5:0]         IDX_LAST   = 6'(N_ELEM - 1);
   localparam logic [4:0]         LAST_C     = 5'(LAST_COUNT);
   localparam logic [4:0]         IDLE_C     = 5'(IDLE_COUNT);
   localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      FEED  = 3'd2,
      DRAIN = 3'd3,
      FIN   = 3'd4
   } seqState_t;

   seqState_t          state;
   logic [5:0]         idx;
   logic [DRAIN_W-1:0] drainCnt;
   logic               hold;

`ifdef LU_SEQ_STALL_EN
   assign hold = stall;
`else
   assign hold = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         idx       <= '0;
         drainCnt  <= '0;
         count     <= IDLE_C;
         array_en  <= 1'b0;
         in_ready  <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         band_flat <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= LOAD;
                  idx      <= '0;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            LOAD: begin
               if (in_valid) begin
                  for (int k = 0; k < N_ELEM; k++) begin
                     if (idx == 6'(k)) band_flat[k*DATA_W +: DATA_W] <= in_data;
                  end
                  if (idx == IDX_LAST) begin
                     state    <= FEED;
                     in_ready <= 1'b0;
                     count    <= '0;
                     array_en <= 1'b1;
                  end else begin
                     idx <= idx + 6'd1;
                  end
               end
            end
            // A held cycle keeps count/state and disables the array on the following cycle
            FEED: begin
               if (hold) begin
                  array_en <= 1'b0;
               end else begin
                  array_en <= 1'b1;
                  if (count == LAST_C) begin
                     state    <= DRAIN;
                     count    <= IDLE_C;
                     drainCnt <= DRAIN_INIT;
                  end else begin
                     count <= count + 5'd1;
                  end
               end
            end
            DRAIN: begin
               if (hold) begin
                  array_en <= 1'b0;
               end else if (drainCnt == '0) begin
                  state    <= FIN;
                  array_en <= 1'b0;
                  done     <= 1'b1;
               end else begin
                  array_en <= 1'b1;
                  drainCnt <= drainCnt - 1'b1;
               end
            end
            FIN: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state    <= IDLE;
               in_ready <= 1'b0;
               array_en <= 1'b0;
               busy     <= 1'b0;
               count    <= IDLE_C;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lu_band_sequencer.sv
// Bench for lu_band_sequencer: directed passes with randomized data/bubbles against a step-counting reference model.
module tb_lu_band_sequencer;

   localparam int DATA_W = 8;
   localparam int N_ELEM = 44;
   localparam int LAST   = 21;
   localparam int DRAIN  = 8;
   localparam int IDLE_C = 31;
   localparam int FW     = DATA_W * N_ELEM;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic in_valid = 1'b0;
   logic stall = 1'b0;
   logic [DATA_W-1:0] in_data = '0;
   logic in_ready;
   logic [FW-1:0] band_flat;
   logic [4:0] count;
   logic array_en;
   logic busy;
   logic done;

   int passCount = 0;
   int checkCount = 0;
   logic [FW-1:0] modelBand = '0;

   lu_band_sequencer #(
      .DATA_W(DATA_W), .N_ELEM(N_ELEM), .LAST_COUNT(LAST),
      .DRAIN_CYCLES(DRAIN), .IDLE_COUNT(IDLE_C)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
`ifdef LU_SEQ_STALL_EN
      .stall(stall),
`endif
      .start(start),
      .in_valid(in_valid),
      .in_data(in_data),
      .in_ready(in_ready),
      .band_flat(band_flat),
      .count(count),
      .array_en(array_en),
      .busy(busy),
      .done(done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
      checkCount++;
      assert (obs === exp) passCount++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic doStart();
      start = 1'b1;
      tick();
      start = 1'b0;
      check("busy_after_start", busy, 1);
      check("ready_after_start", in_ready, 1);
   endtask

   // mode 0: values 1..N continuous; 1: random data, valid toggles 1/0; 2: random data, random bubbles
   task automatic doLoad(input int mode, input int startAt);
      int n;
      int cyc;
      logic v;
      n = 0;
      cyc = 0;
      while (n < N_ELEM && cyc < 400) begin
         if (mode == 0) v = 1'b1;
         else if (mode == 1) v = (cyc % 2 == 0);
         else v = 1'($urandom_range(0, 1));
         in_valid = v;
         in_data = (mode == 0) ? DATA_W'(n + 1) : DATA_W'($urandom);
         start = (n == startAt);
         if (cyc < 3 || n == N_ELEM - 1) check("in_ready_load", in_ready, 1);
         if (v) begin
            modelBand[n*DATA_W +: DATA_W] = in_data;
            n++;
         end
         cyc++;
         tick();
      end
      in_valid = 1'b0;
      start = 1'b0;
      check("load_handshakes", n, N_ELEM);
      if (mode == 1) check("bubbled_load_cycles", cyc, 87);
      check("in_ready_after_load", in_ready, 0);
      check("band_flat_after_load", band_flat, modelBand);
   endtask

   // prog = enabled steps consumed since the last handshake edge
   task automatic runFeed(input int startK, input int rstK, input int stallK, input int stallLen,
                          input bit startAtDone);
      int prog;
      int k;
      int doneK;
      bit lastStall;
      bit fin;
      bit s;
      bit sawDone;
      prog = 0;
      k = 0;
      doneK = -1;
      lastStall = 1'b0;
      fin = 1'b0;
      while (!fin && k < 80) begin
         check($sformatf("count_k%0d", k), count, (prog <= LAST) ? prog : IDLE_C);
         check($sformatf("array_en_k%0d", k), array_en, (prog <= LAST + DRAIN) && !lastStall);
         check($sformatf("done_k%0d", k), done, prog == LAST + DRAIN + 1);
         check($sformatf("busy_k%0d", k), busy, prog <= LAST + DRAIN + 1);
         if (done) doneK = k;
         if (prog >= LAST + DRAIN + 3) begin
            fin = 1'b1;
         end else if (k == rstK) begin
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
            modelBand = '0;
            check("rst_mid_count", count, IDLE_C);
            check("rst_mid_array_en", array_en, 0);
            check("rst_mid_busy", busy, 0);
            check("rst_mid_done", done, 0);
            check("rst_mid_band", band_flat, modelBand);
            sawDone = 1'b0;
            for (int i = 0; i < 40; i++) begin
               tick();
               if (done || busy) sawDone = 1'b1;
            end
            check("rst_mid_no_done", sawDone, 0);
            fin = 1'b1;
         end else begin
            s = (k >= stallK) && (k < stallK + stallLen);
            stall = s;
            start = (k == startK) || (startAtDone && prog == LAST + DRAIN + 1);
            tick();
            if (prog >= LAST + DRAIN + 1 || !s) prog++;
            lastStall = s;
            stall = 1'b0;
            start = 1'b0;
         end
         k++;
      end
      check("feed_finished", fin, 1);
      if (rstK < 0) check("done_latency", doneK, LAST + DRAIN + 1 + stallLen);
   endtask

   initial begin
      // Reset held for two edges, then idle with stray in_valid
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      check("reset_count", count, IDLE_C);
      check("reset_busy", busy, 0);
      check("reset_in_ready", in_ready, 0);
      check("reset_array_en", array_en, 0);
      check("reset_done", done, 0);
      check("reset_band", band_flat, 0);
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_data = DATA_W'($urandom);
         tick();
      end
      in_valid = 1'b0;
      check("idle_no_write", band_flat, 0);
      check("idle_in_ready", in_ready, 0);
      check("idle_busy", busy, 0);

      // Full continuous pass with values 1..44; start held during done is ignored
      doStart();
      doLoad(0, -1);
      check("band_first", band_flat[7:0], 1);
      check("band_last", band_flat[FW-1 -: DATA_W], 44);
      runFeed(-1, -1, 0, 0, 1'b1);

      // Toggled-valid load with start pulses in LOAD (idx 10) and FEED (count 5)
      doStart();
      doLoad(1, 10);
      runFeed(5, -1, 0, 0, 1'b0);

      // Reset at count 12 aborts the pass
      doStart();
      doLoad(2, -1);
      runFeed(-1, 12, 0, 0, 1'b0);

      // Recovery pass after the abort, stalled at count 7 when the feature is built in
      doStart();
      doLoad(2, -1);
`ifdef LU_SEQ_STALL_EN
      runFeed(-1, -1, 7, 3, 1'b0);
`else
      runFeed(-1, -1, 0, 0, 1'b0);
`endif
      check("band_kept_after_done", band_flat, modelBand);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
